benes_route_sequencer: RTL and testbench
========================================

Name: benes_route_sequencer

Overview:
- Queues Benes routing configurations and applies them one at a time to the Interconnect_benes datapath.
- Drives the per-stage module/slot switch selects. Holds each route for a network-settle period plus a programmable data window, then advances to the next queued route.
- Sits between the AXI slave's command storage and the interconnect. It replaces the static "last storage word = switch settings" configuration path.

Parameters:
- STAGE_NUM, 7, number of Benes stages (2*log2(ports)-1).
- SWITCH_NUM, 8, 2x2 switches per stage.
- CFG_DEPTH, 4, route FIFO entries (power of 2, >=2).
- NET_LATENCY, 7, cycles from select change until interconnect outputs are valid (>=1).
- HOLD_W, 8, width of per-route hold-length field.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  asynchronous active-low reset.
- i_cfg_valid  in  1  route push request.
- o_cfg_ready  out  1  FIFO can accept a route.
- i_cfg_module_sel  in  STAGE_NUM*SWITCH_NUM  module-side selects; stage s occupies bits [s*SWITCH_NUM +: SWITCH_NUM].
- i_cfg_slot_sel  in  STAGE_NUM*SWITCH_NUM  slot-side selects; same packing as i_cfg_module_sel.
- i_cfg_hold  in  HOLD_W  data window length minus 1.
- i_enable  in  1  allows new routes to be started.
- i_abort  in  1  synchronous flush/abort.
- o_module_select  out  STAGE_NUM*SWITCH_NUM  to interconnect i_module_select.
- o_slot_select  out  STAGE_NUM*SWITCH_NUM  to interconnect i_slot_select.
- o_window  out  1  interconnect outputs valid for the current route.
- o_done  out  1  one-cycle pulse on the final window cycle.
- o_busy  out  1  state != IDLE.
- o_fifo_count  out  $clog2(CFG_DEPTH)+1  queued entries.

Behaviour:
- Reset (async assert, sync deassert use): FIFO empty, state IDLE, all selects 0, o_window/o_done/o_busy 0, o_cfg_ready 1, counters 0.
- FIFO:
  - Push on i_cfg_valid && o_cfg_ready.
  - o_cfg_ready = (count != CFG_DEPTH). It is low when full, even if a pop occurs that cycle (no full-bypass).
  - A simultaneous push and pop leaves count unchanged.
  - A pushed entry is visible to the FSM the cycle after the push edge (no empty-bypass).
- FSM states: IDLE, SETTLE, HOLD.
- IDLE:
  - If i_enable && count!=0: pop head and register its selects onto o_module_select/o_slot_select at the same edge. Load settle_cnt=0 and hold_cnt=i_cfg_hold of the entry. Go to SETTLE.
  - Otherwise stay. Selects retain their last value, so the route persists.
- SETTLE:
  - settle_cnt increments each cycle.
  - When settle_cnt==NET_LATENCY-1, go to HOLD next edge. SETTLE therefore lasts exactly NET_LATENCY cycles.
- HOLD:
  - o_window=1, combinationally from the state.
  - hold_cnt decrements each cycle. HOLD lasts hold+1 cycles, so hold=0 gives 1 cycle and hold=255 gives 256.
  - o_done=1 during the final HOLD cycle (hold_cnt==0).
  - On the edge ending the final cycle: if i_enable && count!=0, pop and load the next route and enter SETTLE directly (back-to-back, no IDLE cycle). Otherwise go to IDLE.
- i_enable deasserted mid-route does not stop the current route; it only blocks starting the next one.
- i_abort (highest priority after reset):
  - At the next edge: state IDLE, FIFO flushed (count 0), any push that cycle dropped.
  - o_window/o_done go low from that edge. No o_done for the aborted route.
  - Selects retain their current values.
- Widths: settle_cnt sized $clog2(NET_LATENCY)+1. Hold counter is HOLD_W bits, no wrap (it stops at 0).
- Select outputs change only on a pop edge or reset. They are stable throughout SETTLE and HOLD.
- Async reset mid-route: immediate return to reset values, including selects=0. Queued entries are lost.

Test Plan:
- Reset then single push (module_sel=all 1s, slot_sel=0x...A5 pattern, hold=3), enable=1 -> selects update 1 edge after visibility; o_window high exactly 4 cycles starting 7 cycles after the select change; o_done on 4th window cycle; then IDLE, o_busy=0.
- Push 4 routes back-to-back with enable=0 -> o_cfg_ready low after 4th, 5th push dropped, o_fifo_count=4; enable=1 -> 4 routes, each 7 settle + hold+1 window, no IDLE gap, count decrements at each load edge.
- FIFO full, route ends and pops while i_cfg_valid=1 -> push not accepted that cycle (ready low), accepted next cycle, count returns to 4.
- i_abort in 3rd HOLD cycle with 2 queued -> next edge state IDLE, count=0, o_window=0, no o_done, selects unchanged.
- hold=0 and hold=255 routes -> window lengths 1 and 256 cycles respectively, o_done one cycle each.
- Async reset asserted mid-SETTLE (between clock edges) -> selects, o_busy, o_fifo_count zero immediately; o_cfg_ready=1.

Source files
------------

// File: rtl/benes_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : benes_route_sequencer
// Function : Queues Benes routing configurations and applies them one at a
//            time to the interconnect. Each route is held for a fixed
//            network-settle period, then for a programmable data window.
// Revision : 1.0  initial release
// ============================================================================
module benes_route_sequencer #(
    parameter int STAGE_NUM   = 7,
    parameter int SWITCH_NUM  = 8,
    parameter int CFG_DEPTH   = 4,
    parameter int NET_LATENCY = 7,
    parameter int HOLD_W      = 8
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic                            i_cfg_valid,
    output logic                            o_cfg_ready,
    input  logic [STAGE_NUM*SWITCH_NUM-1:0] i_cfg_module_sel,
    input  logic [STAGE_NUM*SWITCH_NUM-1:0] i_cfg_slot_sel,
    input  logic [HOLD_W-1:0]               i_cfg_hold,
    input  logic                            i_enable,
    input  logic                            i_abort,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] o_module_select,
    output logic [STAGE_NUM*SWITCH_NUM-1:0] o_slot_select,
    output logic                            o_window,
    output logic                            o_done,
    output logic                            o_busy,
    output logic [$clog2(CFG_DEPTH):0]      o_fifo_count
);

    localparam int c_SEL_W = STAGE_NUM * SWITCH_NUM;
    localparam int c_PTR_W = $clog2(CFG_DEPTH);
    localparam int c_CNT_W = $clog2(CFG_DEPTH) + 1;
    localparam int c_SET_W = $clog2(NET_LATENCY) + 1;

    localparam logic [c_PTR_W-1:0] c_PTR_ONE     = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE     = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL    = c_CNT_W'(CFG_DEPTH);
    localparam logic [c_SET_W-1:0] c_SET_ONE     = c_SET_W'(1);
    localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(NET_LATENCY - 1);
    localparam logic [HOLD_W-1:0]  c_HOLD_ONE    = HOLD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    // Route FIFO storage
    logic [c_SEL_W-1:0] r_fifo_mod  [CFG_DEPTH];
    logic [c_SEL_W-1:0] r_fifo_slot [CFG_DEPTH];
    logic [HOLD_W-1:0]  r_fifo_hold [CFG_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Sequencer state
    state_t             r_state;
    logic [c_SET_W-1:0] r_settle_cnt;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [c_SEL_W-1:0] r_module_sel;
    logic [c_SEL_W-1:0] r_slot_sel;

    logic w_push;
    logic w_pop;
    logic w_last_hold;
    logic w_can_start;

    // Ready is purely from the occupancy; a same-cycle pop does not free a slot.
    assign o_cfg_ready = (r_count != c_CNT_FULL);
    assign w_push      = i_cfg_valid && o_cfg_ready && !i_abort;
    assign w_last_hold = (r_state == S_HOLD) && (r_hold_cnt == '0);
    assign w_can_start = i_enable && (r_count != '0);
    // A new route is loaded from IDLE, or straight out of the last window cycle.
    assign w_pop       = !i_abort && w_can_start && ((r_state == S_IDLE) || w_last_hold);

    assign o_module_select = r_module_sel;
    assign o_slot_select   = r_slot_sel;
    assign o_window        = (r_state == S_HOLD);
    assign o_done          = w_last_hold;
    assign o_busy          = (r_state != S_IDLE);
    assign o_fifo_count    = r_count;

    // FIFO payload write; contents need no reset since occupancy gates reads.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_push) begin
            r_fifo_mod[r_wr_ptr]  <= i_cfg_module_sel;
            r_fifo_slot[r_wr_ptr] <= i_cfg_slot_sel;
            r_fifo_hold[r_wr_ptr] <= i_cfg_hold;
        end
    end

    // FIFO pointers and occupancy; abort flushes everything.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_abort) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Route FSM: load selects on pop, settle NET_LATENCY cycles, then hold window.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_hold_cnt   <= '0;
            r_module_sel <= '0;
            r_slot_sel   <= '0;
        end else if (i_abort) begin
            // Selects deliberately keep their value so the route stays in place.
            r_state <= S_IDLE;
        end else begin
            if (w_pop) begin
                r_module_sel <= r_fifo_mod[r_rd_ptr];
                r_slot_sel   <= r_fifo_slot[r_rd_ptr];
                r_hold_cnt   <= r_fifo_hold[r_rd_ptr];
                r_settle_cnt <= '0;
                r_state      <= S_SETTLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end
                    S_SETTLE: begin
                        r_settle_cnt <= r_settle_cnt + c_SET_ONE;
                        if (r_settle_cnt == c_SETTLE_LAST) begin
                            r_state <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        if (r_hold_cnt == '0) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_hold_cnt <= r_hold_cnt - c_HOLD_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_benes_route_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_benes_route_sequencer
// Function : Randomized self-checking bench for benes_route_sequencer against
//            a route-age based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_benes_route_sequencer;

    localparam int STAGE_NUM   = 7;
    localparam int SWITCH_NUM  = 8;
    localparam int CFG_DEPTH   = 4;
    localparam int NET_LATENCY = 7;
    localparam int HOLD_W      = 8;
    localparam int W           = STAGE_NUM * SWITCH_NUM;

    logic                     clk;
    logic                     rst_n;
    logic                     i_cfg_valid;
    logic                     o_cfg_ready;
    logic [W-1:0]             i_cfg_module_sel;
    logic [W-1:0]             i_cfg_slot_sel;
    logic [HOLD_W-1:0]        i_cfg_hold;
    logic                     i_enable;
    logic                     i_abort;
    logic [W-1:0]             o_module_select;
    logic [W-1:0]             o_slot_select;
    logic                     o_window;
    logic                     o_done;
    logic                     o_busy;
    logic [$clog2(CFG_DEPTH):0] o_fifo_count;

    benes_route_sequencer #(
        .STAGE_NUM  (STAGE_NUM),
        .SWITCH_NUM (SWITCH_NUM),
        .CFG_DEPTH  (CFG_DEPTH),
        .NET_LATENCY(NET_LATENCY),
        .HOLD_W     (HOLD_W)
    ) u_dut (
        .S_AXI_ACLK      (clk),
        .S_AXI_ARESETN   (rst_n),
        .i_cfg_valid     (i_cfg_valid),
        .o_cfg_ready     (o_cfg_ready),
        .i_cfg_module_sel(i_cfg_module_sel),
        .i_cfg_slot_sel  (i_cfg_slot_sel),
        .i_cfg_hold      (i_cfg_hold),
        .i_enable        (i_enable),
        .i_abort         (i_abort),
        .o_module_select (o_module_select),
        .o_slot_select   (o_slot_select),
        .o_window        (o_window),
        .o_done          (o_done),
        .o_busy          (o_busy),
        .o_fifo_count    (o_fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of routes plus the age of the active route.
    typedef struct {
        logic [W-1:0] m;
        logic [W-1:0] s;
        int           h;
    } ent_t;

    ent_t         m_q[$];
    logic         m_active;
    int           m_age;
    int           m_hold;
    logic [W-1:0] m_mod;
    logic [W-1:0] m_slot;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_window();
        return m_active && (m_age >= NET_LATENCY);
    endfunction

    function automatic logic exp_done();
        return exp_window() && (m_age == NET_LATENCY + m_hold);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_age    = 0;
        m_hold   = 0;
        m_mod    = '0;
        m_slot   = '0;
    endtask

    task automatic check_outputs();
        chk("module_select", 64'(o_module_select), 64'(m_mod));
        chk("slot_select",   64'(o_slot_select),   64'(m_slot));
        chk("window",        64'(o_window),        64'(exp_window()));
        chk("done",          64'(o_done),          64'(exp_done()));
        chk("busy",          64'(o_busy),          64'(m_active));
        chk("fifo_count",    64'(o_fifo_count),    64'(m_q.size()));
        chk("cfg_ready",     64'(o_cfg_ready),     64'(m_q.size() != CFG_DEPTH));
    endtask

    // Advance the model by one clock edge using the inputs presented to it.
    task automatic model_edge();
        int   pre_size;
        logic pre_done;
        ent_t e;
        pre_size = m_q.size();
        pre_done = exp_done();
        if (i_abort) begin
            m_q.delete();
            m_active = 1'b0;
        end else begin
            if (m_active && !pre_done) begin
                m_age++;
            end else if (i_enable && pre_size != 0) begin
                e        = m_q.pop_front();
                m_mod    = e.m;
                m_slot   = e.s;
                m_hold   = e.h;
                m_age    = 0;
                m_active = 1'b1;
            end else begin
                m_active = 1'b0;
            end
            if (i_cfg_valid && pre_size != CFG_DEPTH) begin
                e.m = i_cfg_module_sel;
                e.s = i_cfg_slot_sel;
                e.h = int'(i_cfg_hold);
                m_q.push_back(e);
            end
        end
    endtask

    // Called at a negedge: check, apply inputs, take the edge, return at next negedge.
    task automatic step(input logic v, input logic [W-1:0] m, input logic [W-1:0] s,
                        input int h, input logic en, input logic ab);
        check_outputs();
        i_cfg_valid      = v;
        i_cfg_module_sel = m;
        i_cfg_slot_sel   = s;
        i_cfg_hold       = HOLD_W'(h);
        i_enable         = en;
        i_abort          = ab;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rnd_sel();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[W-1:0];
    endfunction

    function automatic int rnd_hold();
        int k;
        k = $urandom_range(0, 9);
        if (k < 2) return 0;
        if (k < 7) return $urandom_range(1, 4);
        return $urandom_range(5, 20);
    endfunction

    task automatic idle_steps(input int n, input logic en);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 0, en, 1'b0);
    endtask

    task automatic run_random(input int n, input int p_valid, input int p_en, input int p_abort);
        for (int i = 0; i < n; i++) begin
            step(($urandom_range(0, 99) < p_valid), rnd_sel(), rnd_sel(), rnd_hold(),
                 ($urandom_range(0, 99) < p_en), ($urandom_range(0, 999) < p_abort));
        end
    endtask

    initial begin
        logic [W-1:0] ones;
        logic [W-1:0] pat_a5;
        logic         found;
        n_vec = 0;
        n_err = 0;
        ones   = '1;
        pat_a5 = '0;
        for (int i = 0; i < W / 8; i++) pat_a5[i*8 +: 8] = 8'hA5;

        i_cfg_valid      = 1'b0;
        i_cfg_module_sel = '0;
        i_cfg_slot_sel   = '0;
        i_cfg_hold       = '0;
        i_enable         = 1'b0;
        i_abort          = 1'b0;
        rst_n            = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Single route with hold=3
        step(1'b1, ones, pat_a5, 3, 1'b1, 1'b0);
        idle_steps(20, 1'b1);

        // Fill the FIFO with enable low; fifth push must be dropped
        for (int i = 0; i < 5; i++) step(1'b1, rnd_sel(), rnd_sel(), $urandom_range(0, 3), 1'b0, 1'b0);
        idle_steps(2, 1'b0);
        idle_steps(60, 1'b1);

        // Full FIFO draining while pushes keep arriving
        for (int i = 0; i < 4; i++) step(1'b1, rnd_sel(), rnd_sel(), 2, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) step(1'b1, rnd_sel(), rnd_sel(), $urandom_range(0, 2), 1'b1, 1'b0);
        idle_steps(80, 1'b1);

        // Abort in the third window cycle with two routes still queued
        for (int i = 0; i < 3; i++) step(1'b1, rnd_sel(), rnd_sel(), 5, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (m_active && m_age == NET_LATENCY + 2) found = 1'b1;
            else step(1'b0, '0, '0, 0, 1'b1, 1'b0);
        end
        chk("abort_reached", 64'(found), 64'd1);
        step(1'b1, rnd_sel(), rnd_sel(), 1, 1'b1, 1'b1);
        idle_steps(3, 1'b0);

        // Window length extremes
        step(1'b1, rnd_sel(), rnd_sel(), 0, 1'b0, 1'b0);
        step(1'b1, rnd_sel(), rnd_sel(), 255, 1'b0, 1'b0);
        idle_steps(280, 1'b1);

        // Random traffic under several mixes
        run_random(800, 60, 90, 0);
        run_random(800, 90, 40, 5);
        run_random(800, 30, 70, 20);

        // Asynchronous reset between edges while a route is settling
        for (int i = 0; i < 3; i++) step(1'b1, rnd_sel(), rnd_sel(), 4, 1'b0, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (m_active && m_age == 3) found = 1'b1;
            else step(1'b0, '0, '0, 0, 1'b1, 1'b0);
        end
        chk("reset_reached", 64'(found), 64'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_module_select", 64'(o_module_select), 64'd0);
        chk("rst_slot_select",   64'(o_slot_select),   64'd0);
        chk("rst_busy",          64'(o_busy),          64'd0);
        chk("rst_fifo_count",    64'(o_fifo_count),    64'd0);
        chk("rst_cfg_ready",     64'(o_cfg_ready),     64'd1);
        chk("rst_window",        64'(o_window),        64'd0);
        model_reset();
        i_cfg_valid = 1'b0;
        i_enable    = 1'b0;
        i_abort     = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_random(400, 50, 80, 3);
        idle_steps(40, 1'b1);
        check_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
